video_window_clipper: RTL and testbench
=======================================

# video_window_clipper

Crops a rectangular window out of a native video stream (vsync/hsync/de/data) and re-emits it as a native stream with a gated `de`. It sits directly downstream of the test-pattern / capture stage in the clipper path and feeds the VDMA write side. It also reports the measured active size of the clipped output.

## Interface
- `DSIZE`, 24: pixel data width.
- `LAT`, 2: fixed pipeline latency in pclk cycles, applied to all outputs. Legal values are ≥ 2.
- `pclk`  in  1: pixel clock. Only clock.
- `prst`  in  1: reset. Synchronous, active-high.
- `enable`  in  1: 1 = clip, 0 = bypass. Sampled at frame start.
- `top`, `left`, `width`, `height`  in  12 each: window coefficients in pixels/lines. Sampled at frame start.
- `in_vsync`, `in_hsync`, `in_de`  in  1 each: input syncs, active-high.
- `in_data`  in  DSIZE: input pixel.
- `out_vsync`, `out_hsync`  out  1 each: input syncs delayed by LAT.
- `out_de`  out  1: gated data enable.
- `out_data`  out  DSIZE: pixel delayed by LAT. Equals 0 when `out_de`=0.
- `hactive`, `vactive`  out  16 each: measured output width and height.

## Operation
- Frame start (FS) is the rising edge of `in_vsync`, detected against a registered copy.
- At FS the block latches shadow copies of `enable`, `top`, `left`, `width` and `height`. Coefficient changes mid-frame have no effect until the next FS.
- States:
  - `IDLE`: after reset. `out_de` is forced 0 and syncs pass through. Goes to `RUN` on the first FS.
  - `RUN`: normal operation. Stays in `RUN`; only `prst` returns to `IDLE`.
- `h_cnt` (12b):
  - increments on each `in_de`=1 cycle;
  - clears on the falling edge of `in_de`;
  - saturates at 4095.
- `v_cnt` (12b):
  - increments on each falling edge of `in_de`;
  - clears at FS;
  - saturates at 4095.
- Window test, using 13-bit sums to avoid wrap:
  - `h_cnt` ≥ `left` and `h_cnt` < `left`+`width`;
  - `v_cnt` ≥ `top` and `v_cnt` < `top`+`height`.
- `out_de` per state:
  - `RUN` with shadow enable=1: `in_de` AND window test.
  - `RUN` with shadow enable=0: `in_de` (bypass).
  - `IDLE`: 0.
- Boundary cases:
  - `width`=0 or `height`=0: no output `de` for the whole frame.
  - Window extending past the input raster: clipped by the raster. No error, no padding.
- `hactive`:
  - counts output `de` cycles per line;
  - latches the count on the falling edge of `out_de`, zero-extended to 16b.
- `vactive`:
  - counts output lines (falling edges of `out_de`) per frame;
  - latches the count at the delayed FS (rising edge of `out_vsync`), then clears the counter.
  - A frame with zero output lines latches 0.
- A FS coinciding with an `in_de` falling edge: FS wins. `v_cnt` = 0 and the line is not counted.

## Timing
- All outputs are registered.
- Latency from any input to the corresponding output is exactly LAT cycles, with equal latency for syncs, `de` and data. Frame geometry is therefore preserved.
- Reset values: all outputs 0, state `IDLE`, shadows 0, counters 0.
- `prst` asserted mid-frame:
  - outputs are 0 on the next cycle;
  - the partial frame is dropped;
  - the first clipped frame starts at the next FS after reset.
- No back-pressure exists. The block must accept one pixel per cycle continuously.
- `hactive` updates 1 cycle after the `out_de` fall. `vactive` updates 1 cycle after the `out_vsync` rise.

## Structure
- Package `video_clip_pkg` holds:
  - `COORD_W`=12 and `SIZE_W`=16;
  - a state enum `clip_state_e {IDLE, RUN}`;
  - a struct `win_coef_t` {enable, top, left, width, height} for the shadow registers.
- Sub-module `video_pos_counter`:
  - inputs: `pclk`, `prst`, `vsync`, `de`;
  - outputs: `h_cnt`, `v_cnt`, `fs`, `de_fall`.
  - It is instantiated twice: once on the input stream for position, and once on the delayed output stream for `hactive`/`vactive` measurement.
- The pipeline delay is a plain shift-register of LAT stages in the top module.

## Test plan
- **Window clip:** 64×32 raster with hblank 16 and vblank 4; `top`=4, `left`=10, `width`=20, `height`=8.
  - `out_de` is high 20 cycles per line on lines 4–11 only.
  - `out_data` matches the input pixels at x 10..29.
  - After the second frame, `hactive`=20 and `vactive`=8.
- **Bypass:** `enable`=0 on the same raster.
  - `out_*` equal `in_*` delayed exactly 2 cycles.
  - `hactive`=64 and `vactive`=32.
- **Overhang:** `left`=50, `width`=40, `top`=28, `height`=10.
  - `out_de` covers x 50..63 and y 28..31.
  - `hactive`=14 and `vactive`=4.
- **Mid-frame coefficient change:** change `width` from 20 to 8 at line 6.
  - The current frame keeps width 20.
  - The next frame gives `hactive`=8.
- **Zero size:** `width`=0.
  - `out_de` stays 0 all frame and `vactive` latches 0.
  - The syncs still toggle with a 2-cycle delay.
- **Reset mid-frame:** assert `prst` for 3 cycles during line 5.
  - All outputs are 0 the next cycle.
  - `out_de` stays 0 until the next FS.
  - The following frame clips correctly.

Source files
------------

// File: rtl/video_clip_pkg.sv
// Shared types and constants for the video window clipper slice.
package video_clip_pkg;

    localparam int unsigned COORD_W = 12;
    localparam int unsigned SIZE_W  = 16;

    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    typedef enum logic {
        IDLE,
        RUN
    } clip_state_e;

    // Per-frame window coefficients, captured at frame start.
    typedef struct packed {
        logic               enable;
        logic [COORD_W-1:0] top;
        logic [COORD_W-1:0] left;
        logic [COORD_W-1:0] width;
        logic [COORD_W-1:0] height;
    } win_coef_t;

    // True when start <= pos < start + len; the end is formed one bit wider
    // so a window running off the 12-bit range cannot wrap back to zero.
    function automatic logic in_span(
        input logic [COORD_W-1:0] pos,
        input logic [COORD_W-1:0] start,
        input logic [COORD_W-1:0] len
    );
        logic [COORD_W:0] span_end;
        span_end = {1'b0, start} + {1'b0, len};
        return ({1'b0, pos} >= {1'b0, start}) && ({1'b0, pos} < span_end);
    endfunction

endpackage

// File: rtl/video_pos_counter.sv
// Tracks pixel (h) and line (v) position of a native video stream and
// flags frame start (vsync rise) and end of line (de fall).
module video_pos_counter
    import video_clip_pkg::*;
(
    input  logic               pclk,
    input  logic               prst,
    input  logic               vsync,
    input  logic               de,
    output logic [COORD_W-1:0] h_cnt,
    output logic [COORD_W-1:0] v_cnt,
    output logic               fs,
    output logic               de_fall
);

    logic               r_vsync;
    logic               r_de;
    logic [COORD_W-1:0] r_h_cnt;
    logic [COORD_W-1:0] r_v_cnt;

    assign fs      = vsync & ~r_vsync;
    assign de_fall = r_de & ~de;

    // Registered copies of the syncs for edge detection.
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_vsync <= 1'b0;
            r_de    <= 1'b0;
        end else begin
            r_vsync <= vsync;
            r_de    <= de;
        end
    end

    // Pixel counter: counts de cycles in the current line, cleared at line end.
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_h_cnt <= '0;
        end else if (de_fall) begin
            r_h_cnt <= '0;
        end else if (de && (r_h_cnt != COORD_MAX)) begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // Line counter: counts line ends, cleared at frame start (which takes
    // priority over a coincident line end).
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_v_cnt <= '0;
        end else if (fs) begin
            r_v_cnt <= '0;
        end else if (de_fall && (r_v_cnt != COORD_MAX)) begin
            r_v_cnt <= r_v_cnt + 1'b1;
        end
    end

    assign h_cnt = r_h_cnt;
    assign v_cnt = r_v_cnt;

endmodule

// File: rtl/video_window_clipper.sv
// Crops a rectangular window from a native video stream, re-emitting it with
// a gated de after a fixed LAT-cycle delay, and measures the output size.
module video_window_clipper
    import video_clip_pkg::*;
#(
    parameter int unsigned DSIZE = 24,
    parameter int unsigned LAT   = 2
) (
    input  logic               pclk,
    input  logic               prst,
    input  logic               enable,
    input  logic [COORD_W-1:0] top,
    input  logic [COORD_W-1:0] left,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    input  logic               in_vsync,
    input  logic               in_hsync,
    input  logic               in_de,
    input  logic [DSIZE-1:0]   in_data,
    output logic               out_vsync,
    output logic               out_hsync,
    output logic               out_de,
    output logic [DSIZE-1:0]   out_data,
    output logic [SIZE_W-1:0]  hactive,
    output logic [SIZE_W-1:0]  vactive
);

    // ------------------------------------------------------------------
    // Input-side position tracking
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] w_in_h;
    logic [COORD_W-1:0] w_in_v;
    logic               w_in_fs;
    logic               w_unused_in_de_fall;

    video_pos_counter u_in_pos (
        .pclk    (pclk),
        .prst    (prst),
        .vsync   (in_vsync),
        .de      (in_de),
        .h_cnt   (w_in_h),
        .v_cnt   (w_in_v),
        .fs      (w_in_fs),
        .de_fall (w_unused_in_de_fall)
    );

    // ------------------------------------------------------------------
    // Control state and shadow coefficients
    // ------------------------------------------------------------------
    clip_state_e r_state;
    clip_state_e w_state_next;
    win_coef_t   r_coef;
    win_coef_t   w_coef_sample;
    logic        w_in_win;
    logic        w_de_gated;
    logic [DSIZE-1:0] w_data_gated;

    assign w_coef_sample = '{
        enable: enable,
        top:    top,
        left:   left,
        width:  width,
        height: height
    };

    assign w_in_win = in_span(w_in_h, r_coef.left, r_coef.width) &
                      in_span(w_in_v, r_coef.top,  r_coef.height);

    // State register.
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shadow coefficients, refreshed only at frame start.
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_coef <= '0;
        end else if (w_in_fs) begin
            r_coef <= w_coef_sample;
        end
    end

    // Next state and de gating for the incoming pixel.
    always_comb begin
        w_state_next = r_state;
        w_de_gated   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_in_fs) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_de_gated = r_coef.enable ? (in_de & w_in_win) : in_de;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Pixel data is zeroed wherever the gated de is low.
    always_comb begin
        w_data_gated = '0;
        if (w_de_gated) begin
            w_data_gated = in_data;
        end
    end

    // ------------------------------------------------------------------
    // LAT-stage delay line; gating happens before stage 0 so syncs, de and
    // data all see the same number of register stages.
    // ------------------------------------------------------------------
    logic [LAT-1:0]   r_vs_sr;
    logic [LAT-1:0]   r_hs_sr;
    logic [LAT-1:0]   r_de_sr;
    logic [DSIZE-1:0] r_data_sr [LAT];

    // Shift register for syncs, de and pixel data.
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_vs_sr <= '0;
            r_hs_sr <= '0;
            r_de_sr <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                r_data_sr[i] <= '0;
            end
        end else begin
            r_vs_sr      <= {r_vs_sr[LAT-2:0], in_vsync};
            r_hs_sr      <= {r_hs_sr[LAT-2:0], in_hsync};
            r_de_sr      <= {r_de_sr[LAT-2:0], w_de_gated};
            r_data_sr[0] <= w_data_gated;
            for (int unsigned i = 1; i < LAT; i++) begin
                r_data_sr[i] <= r_data_sr[i-1];
            end
        end
    end

    assign out_vsync = r_vs_sr[LAT-1];
    assign out_hsync = r_hs_sr[LAT-1];
    assign out_de    = r_de_sr[LAT-1];
    assign out_data  = r_data_sr[LAT-1];

    // ------------------------------------------------------------------
    // Output-side size measurement
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] w_out_h;
    logic [COORD_W-1:0] w_out_v;
    logic               w_out_fs;
    logic               w_out_de_fall;
    logic [SIZE_W-1:0]  r_hactive;
    logic [SIZE_W-1:0]  r_vactive;

    video_pos_counter u_out_pos (
        .pclk    (pclk),
        .prst    (prst),
        .vsync   (out_vsync),
        .de      (out_de),
        .h_cnt   (w_out_h),
        .v_cnt   (w_out_v),
        .fs      (w_out_fs),
        .de_fall (w_out_de_fall)
    );

    // Latch line width at each output line end and line count at each
    // delayed frame start; the counter clears itself on that same edge.
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_hactive <= '0;
            r_vactive <= '0;
        end else begin
            if (w_out_de_fall) begin
                r_hactive <= {{(SIZE_W-COORD_W){1'b0}}, w_out_h};
            end
            if (w_out_fs) begin
                r_vactive <= {{(SIZE_W-COORD_W){1'b0}}, w_out_v};
            end
        end
    end

    assign hactive = r_hactive;
    assign vactive = r_vactive;

endmodule

// File: tb/tb_video_window_clipper.sv
// Directed bench for video_window_clipper on a 64x32 raster
// (16-cycle hblank, 4-line vblank, vsync on the first vblank line).
module tb_video_window_clipper;

    logic        pclk = 1'b0;
    logic        prst;
    logic        enable;
    logic [11:0] top, left, width, height;
    logic        in_vsync, in_hsync, in_de;
    logic [23:0] in_data;
    logic        out_vsync, out_hsync, out_de;
    logic [23:0] out_data;
    logic [15:0] hactive, vactive;

    video_window_clipper #(
        .DSIZE (24),
        .LAT   (2)
    ) dut (
        .pclk      (pclk),
        .prst      (prst),
        .enable    (enable),
        .top       (top),
        .left      (left),
        .width     (width),
        .height    (height),
        .in_vsync  (in_vsync),
        .in_hsync  (in_hsync),
        .in_de     (in_de),
        .in_data   (in_data),
        .out_vsync (out_vsync),
        .out_hsync (out_hsync),
        .out_de    (out_de),
        .out_data  (out_data),
        .hactive   (hactive),
        .vactive   (vactive)
    );

    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [26:0] exp_q1 = '0, exp_q2 = '0;
    logic        running = 1'b0;
    logic        prev_vs = 1'b0;
    int          m_en = 0, m_top = 0, m_left = 0, m_width = 0, m_height = 0;
    bit          cmp_en = 1'b0;
    bit          chk_rst_next = 1'b0;
    int          stream_err = 0;
    int          de_cnt = 0;
    int          fid = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One pixel clock: sample outputs on the falling edge, then drive inputs
    // and push the expected output (due two cycles later) into the model.
    task automatic cycle(input logic rst, input logic vs, input logic hs,
                         input logic de, input int x, input int y);
        logic [26:0] got;
        logic        e;
        @(negedge pclk);
        got = {out_vsync, out_hsync, out_de, out_data};
        if (cmp_en) begin
            if (got !== exp_q2) stream_err++;
            if (out_de === 1'b1) de_cnt++;
        end
        if (chk_rst_next) begin
            chk_rst_next = 1'b0;
            check("rst_outs_zero", {5'd0, got}, 32'd0);
            check("rst_hactive_zero", {16'd0, hactive}, 32'd0);
            check("rst_vactive_zero", {16'd0, vactive}, 32'd0);
        end
        prst     = rst;
        in_vsync = vs;
        in_hsync = hs;
        in_de    = de;
        in_data  = de ? {8'(fid), 8'(y), 8'(x)} : 24'h5A5A5A;
        if (rst) begin
            running = 1'b0;
            exp_q2  = '0;
            exp_q1  = '0;
        end else begin
            e = running && de &&
                ((m_en == 0) ||
                 (x >= m_left && x < m_left + m_width &&
                  y >= m_top  && y < m_top + m_height));
            exp_q2 = exp_q1;
            exp_q1 = {vs, hs, e, e ? in_data : 24'h0};
            if (vs && !prev_vs) begin
                m_en     = int'(enable);
                m_top    = int'(top);
                m_left   = int'(left);
                m_width  = int'(width);
                m_height = int'(height);
                running  = 1'b1;
            end
        end
        prev_vs = rst ? 1'b0 : vs;
    endtask

    task automatic drive_vblank();
        for (int line = 0; line < 4; line++)
            for (int x = 0; x < 80; x++)
                cycle(1'b0, line == 0, x >= 68 && x < 72, 1'b0, x, 0);
    endtask

    // rst_line/chg_line < 0 disable the mid-frame reset / width change.
    task automatic drive_active(input int rst_line, input int chg_line, input int chg_w);
        logic r;
        fid++;
        de_cnt = 0;
        for (int y = 0; y < 32; y++) begin
            if (y == chg_line) width = 12'(chg_w);
            for (int x = 0; x < 80; x++) begin
                r = (y == rst_line) && x >= 20 && x < 23;
                cycle(r, 1'b0, x >= 68 && x < 72, x < 64, x, y);
                if (r && x == 20) chk_rst_next = 1'b1;
            end
        end
    endtask

    task automatic set_coef(input logic en, input int t, input int l, input int w, input int h);
        enable = en;
        top    = 12'(t);
        left   = 12'(l);
        width  = 12'(w);
        height = 12'(h);
    endtask

    task automatic frame_checks(input string tag, input int exp_de, input int exp_h);
        check({tag, "_stream"}, stream_err, 0);
        check({tag, "_de_count"}, de_cnt, exp_de);
        check({tag, "_hactive"}, {16'd0, hactive}, exp_h);
        stream_err = 0;
    endtask

    initial begin
        prst = 1'b1;
        set_coef(1'b0, 0, 0, 0, 0);
        in_vsync = 1'b0; in_hsync = 1'b0; in_de = 1'b0; in_data = '0;

        repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        cmp_en = 1'b1;
        check("reset_outs", {5'd0, out_vsync, out_hsync, out_de, out_data}, 0);
        check("reset_hactive", {16'd0, hactive}, 0);
        check("reset_vactive", {16'd0, vactive}, 0);

        // Lines before the first frame start: IDLE, de held low.
        set_coef(1'b1, 4, 10, 20, 8);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 80; x++)
                cycle(1'b0, 1'b0, x >= 68 && x < 72, x < 64, x, y);
        check("idle_de_count", de_cnt, 0);
        check("idle_stream", stream_err, 0);
        stream_err = 0;

        // Window clip, two frames.
        drive_vblank();
        check("first_fs_vactive", {16'd0, vactive}, 0);
        drive_active(-1, -1, 0);
        frame_checks("win1", 160, 20);
        drive_vblank();
        check("win1_vactive", {16'd0, vactive}, 8);
        drive_active(-1, -1, 0);
        frame_checks("win2", 160, 20);

        // Bypass.
        set_coef(1'b0, 4, 10, 20, 8);
        drive_vblank();
        check("win2_vactive", {16'd0, vactive}, 8);
        drive_active(-1, -1, 0);
        frame_checks("bypass", 2048, 64);

        // Window overhanging the raster.
        set_coef(1'b1, 28, 50, 40, 10);
        drive_vblank();
        check("bypass_vactive", {16'd0, vactive}, 32);
        drive_active(-1, -1, 0);
        frame_checks("overhang", 56, 14);

        // Width changed mid-frame takes effect one frame later.
        set_coef(1'b1, 4, 10, 20, 8);
        drive_vblank();
        check("overhang_vactive", {16'd0, vactive}, 4);
        drive_active(-1, 6, 8);
        frame_checks("midchg_cur", 160, 20);
        drive_vblank();
        check("midchg_cur_vactive", {16'd0, vactive}, 8);
        drive_active(-1, -1, 0);
        frame_checks("midchg_next", 64, 8);

        // Zero-width window.
        set_coef(1'b1, 4, 10, 0, 8);
        drive_vblank();
        check("midchg_next_vactive", {16'd0, vactive}, 8);
        drive_active(-1, -1, 0);
        check("zero_stream", stream_err, 0);
        check("zero_de_count", de_cnt, 0);
        stream_err = 0;

        // Reset during line 5, then a normal frame.
        set_coef(1'b1, 4, 10, 20, 8);
        drive_vblank();
        check("zero_vactive", {16'd0, vactive}, 0);
        drive_active(5, -1, 0);
        check("rst_frame_stream", stream_err, 0);
        check("rst_frame_hactive", {16'd0, hactive}, 0);
        stream_err = 0;
        drive_vblank();
        check("rst_frame_vactive", {16'd0, vactive}, 0);
        drive_active(-1, -1, 0);
        frame_checks("post_rst", 160, 20);
        drive_vblank();
        check("post_rst_vactive", {16'd0, vactive}, 8);
        check("tail_stream", stream_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
